// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between N_REQ requesters.
// Define RAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module ram_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       ram_cs_n,
    output logic                       ram_we_n,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_din,
    input  logic [DATA_W-1:0]          ram_dout
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic [N_REQ-1:0]  grant;
    logic              hs;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;

    logic              rd1_vld;
    logic [IDX_W-1:0]  rd1_idx;
    logic [N_REQ-1:0]  rd1_onehot;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  last_grant;
`endif

    // Winner search: first asserted request starting after the last grant (or at 0).
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((int'(last_grant) + 1 + k) % int'(N_REQ));
`endif
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign req_ready = rst_n ? grant : '0;
    assign hs        = rst_n & win_found;
    assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_wdata = req_wdata[win_idx*DATA_W +: DATA_W];
    assign win_we    = req_we[win_idx];

    // RAM pins registered from the handshake of the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_cs_n <= ~hs;
            ram_we_n <= ~(hs & win_we);
            if (hs) begin
                ram_addr <= win_addr;
                ram_din  <= win_wdata;
            end
        end
    end

    assign rd1_onehot = N_REQ'(1) << rd1_idx;

    // Read-return tracking: stage 1 follows the RAM access, stage 2 is the response strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_vld   <= 1'b0;
            rd1_idx   <= '0;
            rsp_valid <= '0;
        end else begin
            rd1_vld   <= hs & ~win_we;
            rd1_idx   <= win_idx;
            rsp_valid <= rd1_vld ? rd1_onehot : '0;
        end
    end

    assign rsp_rdata = ram_dout;

`ifndef RAM_ARB_FIXED_PRIO_EN
    // Reset value makes requester 0 the first candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (hs) begin
            last_grant <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed table-driven bench for ram_arbiter with a behavioural 1024x32 RAM.
module tb_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              ram_cs_n;
    logic              ram_we_n;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din;
    logic [DW-1:0]     ram_dout;

    logic [DW-1:0]     mem [0:1023];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [9:0]  base;
        logic [31:0] wdata;
        logic [3:0]  ready;
        logic        cs_n;
        logic        we_n;
        logic [9:0]  raddr;
        logic [31:0] din;
        logic [3:0]  rsp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model; contents 0..15 preset to 0x100+k while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h100 + 32'(k);
        end else if (!ram_cs_n) begin
            if (!ram_we_n) mem[ram_addr] <= ram_din;
            else           ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we, input logic [9:0] b,
                                input logic [31:0] wd, input logic [3:0] rdy, input logic csn,
                                input logic wen, input logic [9:0] ra, input logic [31:0] din,
                                input logic [3:0] rsp, input logic [31:0] rd);
        vec_t t;
        t.valid = v;   t.we = we;     t.base = b;    t.wdata = wd;
        t.ready = rdy; t.cs_n = csn;  t.we_n = wen;  t.raddr = ra;
        t.din = din;   t.rsp = rsp;   t.rdata = rd;
        return t;
    endfunction

    // Requester i uses address base+i; all share the same write data.
    task automatic drive(input logic [3:0] v, input logic [3:0] we, input logic [9:0] b,
                         input logic [31:0] wd);
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = b + AW'(i);
            req_wdata[i*DW +: DW] = wd;
        end
        req_valid = v;
        req_we    = we;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'hF, 4'h0, 10'h0, 32'h0);

        // Common vectors: write/read by requester 1, streaming reads by 2, write/read at top address.
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 1, 1, 10'h000, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h2, 4'h2, 10'h004, 32'hDEADBEEF, 4'h2, 1, 1, 10'h000, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h2, 4'h0, 10'h004, 32'h0,        4'h2, 0, 0, 10'h005, 32'hDEADBEEF, 4'h0, 32'h0));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 0, 1, 10'h005, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 1, 1, 10'h005, 32'h0,        4'h2, 32'hDEADBEEF));
        vecs.push_back(mk(4'h4, 4'h0, 10'h3FE, 32'h0,        4'h4, 1, 1, 10'h005, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h4, 4'h0, 10'h3FF, 32'h0,        4'h4, 0, 1, 10'h000, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h4, 4'h0, 10'h000, 32'h0,        4'h4, 0, 1, 10'h001, 32'h0,        4'h4, 32'h100));
        vecs.push_back(mk(4'h4, 4'h0, 10'h001, 32'h0,        4'h4, 0, 1, 10'h002, 32'h0,        4'h4, 32'h101));
        vecs.push_back(mk(4'h4, 4'h0, 10'h002, 32'h0,        4'h4, 0, 1, 10'h003, 32'h0,        4'h4, 32'h102));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 0, 1, 10'h004, 32'h0,        4'h4, 32'h103));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 1, 1, 10'h004, 32'h0,        4'h4, 32'h104));
        vecs.push_back(mk(4'h1, 4'h1, 10'h3FF, 32'h1,        4'h1, 1, 1, 10'h004, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h2, 4'h0, 10'h3FE, 32'h0,        4'h2, 0, 0, 10'h3FF, 32'h1,        4'h0, 32'h0));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 0, 1, 10'h3FF, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0,        4'h0, 1, 1, 10'h3FF, 32'h0,        4'h2, 32'h1));
`ifdef RAM_ARB_FIXED_PRIO_EN
        // Requesters 0 and 3 both valid: 0 always wins.
        vecs.push_back(mk(4'h9, 4'h0, 10'h000, 32'h0, 4'h1, 1, 1, 10'h3FF, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(4'h9, 4'h0, 10'h000, 32'h0, 4'h1, 0, 1, 10'h000, 32'h0, 4'h0, 32'h0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(4'h9, 4'h0, 10'h000, 32'h0, 4'h1, 0, 1, 10'h000, 32'h0, 4'h1, 32'h100));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0, 4'h0, 0, 1, 10'h000, 32'h0, 4'h1, 32'h100));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0, 4'h0, 1, 1, 10'h000, 32'h0, 4'h1, 32'h100));
`else
        // Park pointer on 3, then all requesters valid: grants 0,1,2,3 repeating.
        vecs.push_back(mk(4'h8, 4'h0, 10'h000, 32'h0, 4'h8, 1, 1, 10'h3FF, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h1, 0, 1, 10'h003, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h2, 0, 1, 10'h000, 32'h0, 4'h8, 32'h103));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h4, 0, 1, 10'h001, 32'h0, 4'h1, 32'h100));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h8, 0, 1, 10'h002, 32'h0, 4'h2, 32'h101));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h1, 0, 1, 10'h003, 32'h0, 4'h4, 32'h102));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h2, 0, 1, 10'h000, 32'h0, 4'h8, 32'h103));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h4, 0, 1, 10'h001, 32'h0, 4'h1, 32'h100));
        vecs.push_back(mk(4'hF, 4'h0, 10'h000, 32'h0, 4'h8, 0, 1, 10'h002, 32'h0, 4'h2, 32'h101));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0, 4'h0, 0, 1, 10'h003, 32'h0, 4'h4, 32'h102));
        vecs.push_back(mk(4'h0, 4'h0, 10'h000, 32'h0, 4'h0, 1, 1, 10'h003, 32'h0, 4'h8, 32'h103));
`endif

        // Reset state, with requests pending.
        @(posedge clk);
        @(negedge clk);
        chk("rst ready",    64'(req_ready), 64'h0);
        chk("rst cs_n",     64'(ram_cs_n),  64'h1);
        chk("rst we_n",     64'(ram_we_n),  64'h1);
        chk("rst ram_addr", 64'(ram_addr),  64'h0);
        chk("rst ram_din",  64'(ram_din),   64'h0);
        chk("rst rsp",      64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        drive(4'h0, 4'h0, 10'h0, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].valid, vecs[i].we, vecs[i].base, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d ready", i),    64'(req_ready), 64'(vecs[i].ready));
            chk($sformatf("v%0d cs_n", i),     64'(ram_cs_n),  64'(vecs[i].cs_n));
            chk($sformatf("v%0d we_n", i),     64'(ram_we_n),  64'(vecs[i].we_n));
            chk($sformatf("v%0d ram_addr", i), 64'(ram_addr),  64'(vecs[i].raddr));
            if (!vecs[i].we_n)
                chk($sformatf("v%0d ram_din", i), 64'(ram_din), 64'(vecs[i].din));
            chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].rsp));
            if (vecs[i].rsp != 4'h0)
                chk($sformatf("v%0d rsp_rdata", i), 64'(rsp_rdata), 64'(vecs[i].rdata));
        end

        // Reset one cycle after a read handshake: the response must be dropped.
        @(posedge clk);
        #1;
        drive(4'h4, 4'h0, 10'h000, 32'h0);
        @(negedge clk);
        chk("mid read ready", 64'(req_ready), 64'h4);
        @(posedge clk);
        #1;
        drive(4'hF, 4'h0, 10'h000, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid rst cs_n",  64'(ram_cs_n),  64'h1);
        chk("mid rst rsp",   64'(rsp_valid), 64'h0);
        chk("mid rst ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("mid rst rsp2",  64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        drive(4'h0, 4'h0, 10'h000, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst cs_n", 64'(ram_cs_n),  64'h1);
        chk("post rst rsp",  64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        drive(4'hF, 4'h0, 10'h000, 32'h0);
        @(negedge clk);
        chk("post rst first grant", 64'(req_ready), 64'h1);
        chk("post rst idle cs_n",   64'(ram_cs_n),  64'h1);
        @(posedge clk);
        #1;
        drive(4'h0, 4'h0, 10'h000, 32'h0);
        @(negedge clk);
        chk("post rst access cs_n", 64'(ram_cs_n), 64'h0);
        chk("post rst access addr", 64'(ram_addr), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("post rst rsp_valid", 64'(rsp_valid), 64'h1);
        chk("post rst rsp_rdata", 64'(rsp_rdata), 64'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
